// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register.
//   mode_e  : operation select carried on the 3-bit mode port
//   state_e : burst engine state
//   is_shift_mode() : true for modes that move bits (and so can run a burst)
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'd0,
        MODE_LOAD  = 3'd1,
        MODE_SHL   = 3'd2,
        MODE_SHR   = 3'd3,
        MODE_ROL   = 3'd4,
        MODE_ROR   = 3'd5,
        MODE_ASR   = 3'd6,
        MODE_HOLD7 = 3'd7
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m >= MODE_SHL) && (m <= MODE_ASR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational step of the universal shift register.
// Ports:
//   q        in  WIDTH  current register contents
//   s_out    in  1      current serial-out value (kept for LOAD/HOLD)
//   mode     in  3      operation (mode_e encoding)
//   s_in     in  1      serial input for SHL/SHR
//   p_in     in  WIDTH  parallel load data
//   q_next   out WIDTH  register contents after the step
//   s_next   out 1      serial-out value after the step
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             s_out,
    input  logic [2:0]       mode,
    input  logic             s_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] q_next,
    output logic             s_next
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned -- otherwise synthesis infers a latch.
        q_next = q;
        s_next = s_out;
        case (mode)
            MODE_LOAD: q_next = p_in;
            MODE_SHL: begin
                q_next = {q[WIDTH-2:0], s_in};
                s_next = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next = {s_in, q[WIDTH-1:1]};
                s_next = q[0];
            end
            MODE_ROL: begin
                q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                s_next = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next = {q[0], q[WIDTH-1:1]};
                s_next = q[0];
            end
            MODE_ASR: begin
                q_next = {q[WIDTH-1], q[WIDTH-1:1]};
                s_next = q[0];
            end
            default: ;  // HOLD and code 7 leave everything as is
        endcase
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register with a burst engine.
// Ports:
//   clk    in  1      rising-edge clock
//   rst_n  in  1      asynchronous active-low reset
//   en     in  1      manual single-step enable (IDLE only)
//   mode   in  3      HOLD/LOAD/SHL/SHR/ROL/ROR/ASR/HOLD
//   s_in   in  1      serial input
//   p_in   in  WIDTH  parallel load data
//   start  in  1      burst request (IDLE only, wins over en)
//   shamt  in  CW     burst step count, clamped to WIDTH
//   Q      out WIDTH  register contents
//   s_out  out 1      bit moved out by the last step
//   busy   out 1      burst in progress
//   done   out 1      one-cycle completion pulse
module shift_reg_univ
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             s_in,
    input  logic [WIDTH-1:0] p_in,
    input  logic             start,
    input  logic [CW-1:0]    shamt,
    output logic [WIDTH-1:0] Q,
    output logic             s_out,
    output logic             busy,
    output logic             done
);

    state_e           state, state_nx;
    logic [2:0]       run_mode, run_mode_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [CW-1:0]    eff_shamt;
    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_q, q_nx;
    logic             step_s, s_nx;
    logic             busy_nx, done_nx;

    // A single step unit serves both manual operation and the burst engine.
    assign step_mode = (state == ST_RUN) ? run_mode : mode;
    assign eff_shamt = (shamt > CW'(WIDTH)) ? CW'(WIDTH) : shamt;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q      (Q),
        .s_out  (s_out),
        .mode   (step_mode),
        .s_in   (s_in),
        .p_in   (p_in),
        .q_next (step_q),
        .s_next (step_s)
    );

    always_comb begin
        state_nx    = state;
        run_mode_nx = run_mode;
        cnt_nx      = cnt;
        q_nx        = Q;
        s_nx        = s_out;
        busy_nx     = busy;
        done_nx     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    run_mode_nx = mode;
                    if (!is_shift_mode(mode)) begin
                        // HOLD/LOAD complete in a single edge regardless of shamt
                        q_nx    = step_q;
                        s_nx    = step_s;
                        done_nx = 1'b1;
                    end else if (eff_shamt == '0) begin
                        // zero steps: nothing moves, completion still reported
                        done_nx = 1'b1;
                    end else begin
                        q_nx = step_q;
                        s_nx = step_s;
                        if (eff_shamt == CW'(1)) begin
                            done_nx = 1'b1;
                        end else begin
                            cnt_nx   = eff_shamt - CW'(1);
                            state_nx = ST_RUN;
                            busy_nx  = 1'b1;
                        end
                    end
                end else if (en) begin
                    q_nx = step_q;
                    s_nx = step_s;
                end
            end
            ST_RUN: begin
                q_nx   = step_q;
                s_nx   = step_s;
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx = ST_IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            run_mode <= MODE_HOLD;
            cnt      <= '0;
            Q        <= '0;
            s_out    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            run_mode <= run_mode_nx;
            cnt      <= cnt_nx;
            Q        <= q_nx;
            s_out    <= s_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ (WIDTH=8).
module tb_shift_reg_univ;
    import shift_pkg::*;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [2:0]       mode;
    logic             s_in;
    logic [WIDTH-1:0] p_in;
    logic             start;
    logic [CW-1:0]    shamt;
    logic [WIDTH-1:0] Q;
    logic             s_out;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;

    shift_reg_univ #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .s_in  (s_in),
        .p_in  (p_in),
        .start (start),
        .shamt (shamt),
        .Q     (Q),
        .s_out (s_out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q0;
        logic [2:0] mode;
        logic       en;
        logic       s_in;
        logic [7:0] exp_q;
        logic       chk_s;
        logic       exp_s;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        mode = MODE_LOAD; en = 1'b1; p_in = val;
        tick();
        en = 1'b0; mode = MODE_HOLD;
    endtask

    // Start a burst and count edges until done appears (bounded).
    task automatic burst(input logic [2:0] m, input logic [CW-1:0] n, output int edges,
                         output int busy_cycles);
        mode = m; shamt = n; start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1; busy_cycles = 0;
        while (!done && edges < 20) begin
            if (busy) busy_cycles++;
            tick();
            edges++;
        end
    endtask

    vec_t vecs[11];
    int   edges, bcyc, seen_done;
    logic [7:0] ser_bits;

    initial begin
        vecs[0]  = '{8'h55, MODE_SHL,   1'b1, 1'b1, 8'hAB, 1'b1, 1'b0};
        vecs[1]  = '{8'h80, MODE_SHL,   1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[2]  = '{8'h01, MODE_SHR,   1'b1, 1'b1, 8'h80, 1'b1, 1'b1};
        vecs[3]  = '{8'hAA, MODE_SHR,   1'b1, 1'b0, 8'h55, 1'b1, 1'b0};
        vecs[4]  = '{8'h81, MODE_ROL,   1'b1, 1'b0, 8'h03, 1'b1, 1'b1};
        vecs[5]  = '{8'h81, MODE_ROR,   1'b1, 1'b0, 8'hC0, 1'b1, 1'b1};
        vecs[6]  = '{8'h80, MODE_ASR,   1'b1, 1'b0, 8'hC0, 1'b1, 1'b0};
        vecs[7]  = '{8'h41, MODE_ASR,   1'b1, 1'b1, 8'h20, 1'b1, 1'b1};
        vecs[8]  = '{8'h3C, MODE_HOLD,  1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[9]  = '{8'h3C, MODE_HOLD7, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[10] = '{8'h3C, MODE_SHL,   1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};

        rst_n = 1'b0; en = 1'b0; mode = MODE_HOLD; s_in = 1'b0;
        p_in = '0; start = 1'b0; shamt = '0;
        #12;
        check("reset_q", Q, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_s_out", s_out, 1'b0);
        rst_n = 1'b1;
        tick();

        // Table-driven single steps
        for (int i = 0; i < 11; i++) begin
            load(vecs[i].q0);
            mode = vecs[i].mode; en = vecs[i].en; s_in = vecs[i].s_in;
            tick();
            en = 1'b0;
            check($sformatf("vec%0d_q", i), Q, vecs[i].exp_q);
            if (vecs[i].chk_s) check($sformatf("vec%0d_s_out", i), s_out, vecs[i].exp_s);
            check($sformatf("vec%0d_done", i), done, 1'b0);
        end

        // Burst ROR 3 from 0x81
        load(8'h81);
        mode = MODE_ROR; shamt = 4'd3; start = 1'b1;
        tick(); start = 1'b0;
        check("ror_q1", Q, 8'hC0); check("ror_busy1", busy, 1'b1); check("ror_done1", done, 1'b0);
        tick();
        check("ror_q2", Q, 8'h60); check("ror_busy2", busy, 1'b1); check("ror_done2", done, 1'b0);
        tick();
        check("ror_q3", Q, 8'h30); check("ror_busy3", busy, 1'b0); check("ror_done3", done, 1'b1);
        check("ror_s_out", s_out, 1'b0);
        tick();
        check("ror_done_clear", done, 1'b0);

        // Burst ASR 8 from 0x80 with a stray start mid-burst
        load(8'h80);
        mode = MODE_ASR; shamt = 4'd8; start = 1'b1;
        tick(); start = 1'b0;
        edges = 1;
        while (!done && edges < 20) begin
            if (edges == 3) begin
                start = 1'b1; shamt = 4'd2; mode = MODE_SHL;
            end else begin
                start = 1'b0; mode = MODE_HOLD;
            end
            tick();
            edges++;
        end
        start = 1'b0;
        check("asr_edges", edges, 8);
        check("asr_q", Q, 8'hFF);
        check("asr_s_out", s_out, 1'b1);

        // Deserialize 1,0,1,1,0,0,1,0 via SHL burst of 8
        load(8'h00);
        ser_bits = 8'b1011_0010;
        mode = MODE_SHL; shamt = 4'd8; start = 1'b1; s_in = ser_bits[7];
        tick(); start = 1'b0;
        edges = 1;
        while (!done && edges < 20) begin
            s_in = (edges < 8) ? ser_bits[7 - edges] : 1'b0;
            tick();
            edges++;
        end
        check("deser_edges", edges, 8);
        check("deser_q", Q, 8'hB2);

        // shamt=0 with SHL: no movement, done next cycle, never busy
        load(8'h5A);
        mode = MODE_SHL; shamt = 4'd0; start = 1'b1; s_in = 1'b1;
        tick(); start = 1'b0;
        check("sh0_q", Q, 8'h5A); check("sh0_done", done, 1'b1); check("sh0_busy", busy, 1'b0);
        tick();
        check("sh0_done_clear", done, 1'b0);

        // shamt=1: single step, immediate done
        load(8'h01);
        s_in = 1'b0;
        burst(MODE_SHL, 4'd1, edges, bcyc);
        check("sh1_edges", edges, 1); check("sh1_q", Q, 8'h02); check("sh1_busy", busy, 1'b0);

        // LOAD via start: loads and completes in one edge
        p_in = 8'hE7;
        burst(MODE_LOAD, 4'd5, edges, bcyc);
        check("ldstart_edges", edges, 1); check("ldstart_q", Q, 8'hE7); check("ldstart_busy", busy, 1'b0);

        // shamt=12 clamps to 8 steps: ROL of 0x01 returns to 0x01
        load(8'h01);
        burst(MODE_ROL, 4'd12, edges, bcyc);
        check("clamp_edges", edges, 8); check("clamp_busy_cycles", bcyc, 7); check("clamp_q", Q, 8'h01);

        // Back-to-back: new start accepted in the done cycle
        mode = MODE_ROL; shamt = 4'd1; start = 1'b1;
        tick(); start = 1'b0;
        check("b2b_q", Q, 8'h02); check("b2b_done", done, 1'b1);

        // Reset mid-burst
        load(8'h9E);
        mode = MODE_SHL; shamt = 4'd8; start = 1'b1; s_in = 1'b0;
        tick(); start = 1'b0;
        check("rst_pre_q", Q, 8'h3C); check("rst_pre_busy", busy, 1'b1); check("rst_pre_s_out", s_out, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_q", Q, 8'h00); check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0); check("rst_mid_s_out", s_out, 1'b0);
        #1 rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) seen_done++;
        end
        check("rst_no_done_after", seen_done, 0);
        check("rst_q_after", Q, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal shift register; successor to the fixed 8-bit shift/load register.
- Adds width parameter, asynchronous active-low reset, rotate and arithmetic modes, and serial-out.
- Adds a burst engine that performs N shift steps autonomously, with busy/done status.
- Used as a serializer/deserializer and barrel-step shifter feeding datapath and display blocks.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CW, $clog2(WIDTH+1), width of the shift-amount port (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  manual-operation enable (IDLE only).
- mode  in  3  operation select: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 HOLD.
- s_in  in  1  serial input for SHL/SHR.
- p_in  in  WIDTH  parallel load data.
- start  in  1  burst request; sampled in IDLE only.
- shamt  in  CW  burst step count, 0..WIDTH.
- Q  out  WIDTH  register contents.
- s_out  out  1  registered; the bit shifted or rotated out by the last step.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset: the following are cleared asynchronously while rst_n=0, with state forced to IDLE:
  - Q=0, s_out=0, busy=0, done=0, step counter=0.
- Reset asserted mid-burst aborts the burst; no done pulse is issued.
- Single step, using the Q value before the edge:
  - SHL: Q<={Q[W-2:0],s_in}, s_out<=Q[W-1].
  - SHR: Q<={s_in,Q[W-1:1]}, s_out<=Q[0].
  - ROL: Q<={Q[W-2:0],Q[W-1]}, s_out<=Q[W-1].
  - ROR: Q<={Q[0],Q[W-1:1]}, s_out<=Q[0].
  - ASR: Q<={Q[W-1],Q[W-1:1]}, s_out<=Q[0].
  - LOAD: Q<=p_in, s_out unchanged.
  - HOLD/7: no change.
- State machine has two states, IDLE and RUN.
- IDLE, start=1 (takes priority over en):
  - Latch mode into run_mode.
  - shamt=0 or mode in {HOLD, LOAD, 7}: perform the single step (LOAD loads, HOLD nothing). done=1 next cycle; stay in IDLE.
  - shamt=1: perform one step on this edge; done=1; stay in IDLE.
  - shamt>=2: perform one step on this edge; cnt<=shamt-1; go to RUN; busy=1.
  - shamt>WIDTH: clamp to WIDTH.
- IDLE, start=0, en=1: perform one step of mode. done stays 0.
- IDLE, start=0, en=0: hold.
- RUN:
  - Each edge performs one step of run_mode; s_in is sampled fresh every edge.
  - cnt decrements each step.
  - On the edge where cnt goes 1->0: return to IDLE, busy<=0, done<=1.
  - start, en, mode and p_in are ignored while in RUN.
- Timing: a burst of N>=2 steps occupies N edges, with busy high for N-1 cycles. done is high for exactly the cycle after the final step; a new start is accepted in that same cycle.
- done is 0 in every cycle other than the completion cycle.

Decomposition:
- Package shift_pkg:
  - Mode encoding constants MODE_HOLD..MODE_ASR.
  - State encoding ST_IDLE/ST_RUN.
- Sub-module shift_step (combinational):
  - Inputs: Q, mode, s_in.
  - Outputs: next Q, next s_out.
  - Instantiated once; the top selects its mode input from mode or run_mode.
- The top holds the FSM, counter and registers.

Test Plan (WIDTH=8):
- Reset: pulse rst_n=0 between clock edges during a burst (Q=0x3C, busy=1) -> Q=0x00, busy=0, done=0, s_out=0 immediately; no done afterwards.
- Load then manual SHL: mode=LOAD, en=1, p_in=0x55 -> Q=0x55; then mode=SHL, s_in=1 -> Q=0xAB, s_out=0.
- Burst ROR: Q=0x81, start with mode=ROR, shamt=3 -> Q goes 0xC0, 0x60, 0x30 on successive edges; busy high 2 cycles; done pulses once; s_out=0.
- Burst ASR with ignored start: Q=0x80, mode=ASR, shamt=8 -> Q=0xFF after 8 edges. A start with shamt=2 asserted mid-burst is ignored; count stays 8.
- Deserialize: Q=0x00, mode=SHL, shamt=8, s_in sequence 1,0,1,1,0,0,1,0 -> Q=0xB2; done after the 8th edge.
- Edge counts:
  - shamt=0 with mode=SHL -> Q unchanged, done=1 next cycle, busy never high.
  - shamt=12 -> clamped to 8 steps.
